// File: rtl/atomos_pkg.sv
// Shared definitions for the atomos 24-bit multicycle core: opcodes, condition
// codes, special-register indices, flag bit positions and the phase encoding.
package atomos_pkg;

  localparam logic [3:0] OPC_NOP   = 4'h0;
  localparam logic [3:0] OPC_MOVI  = 4'h1;
  localparam logic [3:0] OPC_MOV   = 4'h2;
  localparam logic [3:0] OPC_ADD   = 4'h3;
  localparam logic [3:0] OPC_SUB   = 4'h4;
  localparam logic [3:0] OPC_AND   = 4'h5;
  localparam logic [3:0] OPC_OR    = 4'h6;
  localparam logic [3:0] OPC_XOR   = 4'h7;
  localparam logic [3:0] OPC_CMP   = 4'h8;
  localparam logic [3:0] OPC_LD    = 4'h9;
  localparam logic [3:0] OPC_ST    = 4'hA;
  localparam logic [3:0] OPC_JCC   = 4'hB;
  localparam logic [3:0] OPC_JAL   = 4'hC;
  localparam logic [3:0] OPC_RET   = 4'hD;
  localparam logic [3:0] OPC_MOVSR = 4'hE;
  localparam logic [3:0] OPC_HLT   = 4'hF;

  localparam logic [3:0] CC_AL = 4'h0;
  localparam logic [3:0] CC_EQ = 4'h1;
  localparam logic [3:0] CC_NE = 4'h2;
  localparam logic [3:0] CC_CS = 4'h3;
  localparam logic [3:0] CC_CC = 4'h4;
  localparam logic [3:0] CC_MI = 4'h5;
  localparam logic [3:0] CC_PL = 4'h6;
  localparam logic [3:0] CC_VS = 4'h7;
  localparam logic [3:0] CC_VC = 4'h8;

  localparam logic [2:0] SR_FL  = 3'd0;
  localparam logic [2:0] SR_LR  = 3'd1;
  localparam logic [2:0] SR_ST  = 3'd2;
  localparam logic [2:0] SR_SSP = 3'd3;

  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_N = 1;
  localparam int unsigned FLAG_C = 2;
  localparam int unsigned FLAG_V = 3;

  typedef enum logic [2:0] {
    PH_IA, PH_IF, PH_ID, PH_EX, PH_MA, PH_MO, PH_WB, PH_HALT
  } phase_t;

  function automatic logic cond_met(input logic [3:0] cc, input logic [3:0] fl);
    case (cc)
      CC_AL:   return 1'b1;
      CC_EQ:   return fl[FLAG_Z];
      CC_NE:   return !fl[FLAG_Z];
      CC_CS:   return fl[FLAG_C];
      CC_CC:   return !fl[FLAG_C];
      CC_MI:   return fl[FLAG_N];
      CC_PL:   return !fl[FLAG_N];
      CC_VS:   return fl[FLAG_V];
      CC_VC:   return !fl[FLAG_V];
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic writes_rd(input logic [3:0] opc);
    case (opc)
      OPC_MOVI, OPC_MOV, OPC_ADD, OPC_SUB, OPC_AND, OPC_OR, OPC_XOR,
      OPC_LD, OPC_MOVSR: return 1'b1;
      default:           return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/atomos_alu.sv
// Combinational ALU: result and new {V,C,N,Z} for the executing opcode.
// Opcodes without an ALU function pass operand b through unchanged.
module atomos_alu
  import atomos_pkg::*;
#(
  parameter int unsigned DW = 24
) (
  input  logic [3:0]    opc,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] result,
  output logic [3:0]    flags,
  output logic          flags_we
);

  logic [DW:0] sum;
  logic [DW:0] diff;

  always_comb begin
    sum      = {1'b0, a} + {1'b0, b};
    // a + ~b + 1: the carry out is the no-borrow flag
    diff     = {1'b0, a} + {1'b0, ~b} + (DW+1)'(1);
    result   = b;
    flags    = '0;
    flags_we = 1'b0;
    case (opc)
      OPC_ADD: begin
        result        = sum[DW-1:0];
        flags_we      = 1'b1;
        flags[FLAG_C] = sum[DW];
        flags[FLAG_V] = (a[DW-1] == b[DW-1]) && (sum[DW-1] != a[DW-1]);
      end
      OPC_SUB, OPC_CMP: begin
        result        = diff[DW-1:0];
        flags_we      = 1'b1;
        flags[FLAG_C] = diff[DW];
        flags[FLAG_V] = (a[DW-1] != b[DW-1]) && (diff[DW-1] != a[DW-1]);
      end
      OPC_AND: begin result = a & b; flags_we = 1'b1; end
      OPC_OR:  begin result = a | b; flags_we = 1'b1; end
      OPC_XOR: begin result = a ^ b; flags_we = 1'b1; end
      default: ;
    endcase
    if (flags_we) begin
      flags[FLAG_Z] = (result == '0);
      flags[FLAG_N] = result[DW-1];
    end
  end

endmodule

// File: rtl/atomos_core.sv
// atomos 24-bit multicycle CPU with private instruction ROM and data RAM.
// Each instruction walks IA, IF, ID, EX, [MA, [MO]], WB; HLT parks in HALT.
module atomos_core
  import atomos_pkg::*;
#(
  parameter int unsigned DW        = 24,
  parameter int unsigned AW        = 12,
  parameter string       IMEM_FILE = "imem.hex"
) (
  input logic iw_clk,
  input logic iw_rst
);

  localparam int unsigned MEM_WORDS = 1 << AW;

  logic [AW-1:0] r_pc, r_iaddr, r_addr, pc_inc;
  logic [DW-1:0] r_gp   [0:15];
  logic [DW-1:0] r_sr   [0:7];
  logic [DW-1:0] r_imem [0:MEM_WORDS-1];
  logic [DW-1:0] r_dmem [0:MEM_WORDS-1];
  logic [DW-1:0] r_instr, r_a, r_b, r_res, r_mdata;
  logic [3:0]    r_flags;
  logic          r_flags_we, r_take;
  phase_t        r_phase, phase_nxt;

  logic [3:0]    opc, rd, rs;
  logic [11:0]   imm;
  logic [DW-1:0] alu_res;
  logic [3:0]    alu_flags;
  logic          alu_fwe;

  assign opc    = r_instr[23:20];
  assign rd     = r_instr[19:16];
  assign rs     = r_instr[15:12];
  assign imm    = r_instr[11:0];
  assign pc_inc = r_pc + AW'(1);

  atomos_alu #(.DW(DW)) u_alu (
    .opc      (opc),
    .a        (r_a),
    .b        (r_b),
    .result   (alu_res),
    .flags    (alu_flags),
    .flags_we (alu_fwe)
  );

  always_comb begin
    phase_nxt = r_phase;
    case (r_phase)
      PH_IA:   phase_nxt = PH_IF;
      PH_IF:   phase_nxt = PH_ID;
      PH_ID:   phase_nxt = PH_EX;
      PH_EX:   phase_nxt = (opc == OPC_LD || opc == OPC_ST) ? PH_MA : PH_WB;
      PH_MA:   phase_nxt = (opc == OPC_LD) ? PH_MO : PH_WB;
      PH_MO:   phase_nxt = PH_WB;
      PH_WB:   phase_nxt = (opc == OPC_HLT) ? PH_HALT : PH_IA;
      PH_HALT: phase_nxt = PH_HALT;
      default: phase_nxt = PH_IA;
    endcase
  end

  always_ff @(posedge iw_clk or negedge iw_rst) begin
    if (!iw_rst) begin
      r_phase    <= PH_IA;
      r_pc       <= '0;
      r_iaddr    <= '0;
      r_addr     <= '0;
      r_instr    <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_res      <= '0;
      r_mdata    <= '0;
      r_flags    <= '0;
      r_flags_we <= 1'b0;
      r_take     <= 1'b0;
      for (int unsigned i = 0; i < 16; i++) r_gp[i] <= '0;
      for (int unsigned i = 0; i < 8; i++)  r_sr[i] <= '0;
      r_sr[SR_SSP] <= DW'(12'hFFF);
    end else begin
      r_phase <= phase_nxt;
      case (r_phase)
        PH_IA: r_iaddr <= r_pc;
        PH_IF: r_instr <= r_imem[r_iaddr];
        PH_ID: begin
          r_a <= r_gp[rd];
          case (opc)
            OPC_MOVI:  r_b <= DW'(imm);
            OPC_MOVSR: r_b <= r_sr[rs[2:0]];
            default:   r_b <= r_gp[rs];
          endcase
        end
        PH_EX: begin
          r_res      <= alu_res;
          r_flags    <= alu_flags;
          r_flags_we <= alu_fwe;
          r_take     <= (opc == OPC_JAL) ||
                        (opc == OPC_JCC && cond_met(rd, r_sr[SR_FL][3:0]));
          r_addr     <= r_b[AW-1:0] + imm[AW-1:0];
        end
        PH_MO: r_mdata <= r_dmem[r_addr];
        PH_WB: begin
          if (writes_rd(opc)) r_gp[rd] <= (opc == OPC_LD) ? r_mdata : r_res;
          if (r_flags_we)     r_sr[SR_FL] <= DW'(r_flags);
          if (opc == OPC_JAL) r_sr[SR_LR] <= DW'(pc_inc);
          if (opc == OPC_HLT)      r_sr[SR_ST][0] <= 1'b1;
          else if (opc == OPC_RET) r_pc <= r_sr[SR_LR][AW-1:0];
          else if (r_take)         r_pc <= imm[AW-1:0];
          else                     r_pc <= pc_inc;
        end
        default: ;
      endcase
    end
  end

  // RAM is not reset; the async reset forces IA, so a store whose MA edge
  // has not yet happened is simply dropped.
  always_ff @(posedge iw_clk) begin
    if (r_phase == PH_MA && opc == OPC_ST) r_dmem[r_addr] <= r_a;
  end

endmodule

// File: tb/tb_atomos_core.sv
// Directed-program bench for atomos_core: programs are placed in the ROM
// through hierarchy while reset is held, then architectural state is checked.
module tb_atomos_core;
  import atomos_pkg::*;

  logic iw_clk = 1'b0;
  logic iw_rst = 1'b0;
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [11:0] trace  [$];
  int unsigned ia_cyc [$];

  logic [11:0] exp_br   [10] = '{12'h000, 12'h001, 12'h002, 12'h010, 12'h011,
                                 12'h012, 12'h005, 12'h020, 12'h006, 12'h007};
  logic [11:0] exp_wrap [6]  = '{12'h000, 12'h001, 12'h002, 12'hFFF, 12'h000, 12'h003};

  atomos_core #(.DW(24), .AW(12), .IMEM_FILE("")) dut (
    .iw_clk (iw_clk),
    .iw_rst (iw_rst)
  );

  always #5 iw_clk = ~iw_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [23:0] enc(input logic [3:0] opc, input logic [3:0] rd,
                                      input logic [3:0] rs, input logic [11:0] imm);
    return {opc, rd, rs, imm};
  endfunction

  task automatic hold_reset();
    iw_rst = 1'b0;
    for (int i = 0; i < 4096; i++) dut.r_imem[i] = '0;
    repeat (2) @(posedge iw_clk);
    @(negedge iw_clk);
  endtask

  task automatic put(input int unsigned a, input logic [23:0] w);
    dut.r_imem[a] = w;
  endtask

  task automatic run_to_halt();
    trace.delete();
    ia_cyc.delete();
    iw_rst = 1'b1;
    for (int i = 0; i < 2000 && dut.r_phase != PH_HALT; i++) begin
      if (dut.r_phase == PH_IA) begin
        trace.push_back(dut.r_pc);
        ia_cyc.push_back(i);
      end
      @(negedge iw_clk);
    end
    check("reached_halt", 32'(dut.r_phase), 32'(PH_HALT));
  endtask

  task automatic load_arith();
    put(0, enc(OPC_MOVI, 4'd1, 4'd0, 12'd5));
    put(1, enc(OPC_MOVI, 4'd2, 4'd0, 12'd7));
    put(2, enc(OPC_ADD,  4'd1, 4'd2, 12'd0));
    put(3, enc(OPC_SUB,  4'd2, 4'd2, 12'd0));
    put(4, enc(OPC_HLT,  4'd0, 4'd0, 12'd0));
  endtask

  initial begin
    logic [23:0] acc;
    logic        found;

    // reset state
    hold_reset();
    acc = '0;
    for (int i = 0; i < 16; i++) acc = acc | dut.r_gp[i];
    check("rst_pc",    32'(dut.r_pc), 32'h0);
    check("rst_phase", 32'(dut.r_phase), 32'(PH_IA));
    check("rst_gp_or", 32'(acc), 32'h0);
    check("rst_ssp",   32'(dut.r_sr[3]), 32'h000FFF);
    check("rst_fl",    32'(dut.r_sr[0]), 32'h0);
    check("rst_st",    32'(dut.r_sr[2]), 32'h0);

    // arithmetic and halt
    hold_reset();
    load_arith();
    run_to_halt();
    check("arith_r1",  32'(dut.r_gp[1]), 32'h00000C);
    check("arith_r2",  32'(dut.r_gp[2]), 32'h0);
    check("arith_fl",  32'(dut.r_sr[0]), 32'h5);
    check("arith_st0", 32'(dut.r_sr[2][0]), 32'h1);
    check("arith_pc",  32'(dut.r_pc), 32'h4);
    repeat (5) @(negedge iw_clk);
    check("halt_pc_held",    32'(dut.r_pc), 32'h4);
    check("halt_phase_held", 32'(dut.r_phase), 32'(PH_HALT));

    // signed overflow: 0x7FFFFF + 1
    hold_reset();
    put(0, enc(OPC_MOVI, 4'd1, 4'd0, 12'h7FF));
    for (int i = 1; i <= 12; i++) put(i, enc(OPC_ADD, 4'd1, 4'd1, 12'd0));
    put(13, enc(OPC_MOVI, 4'd3, 4'd0, 12'hFFF));
    put(14, enc(OPC_OR,   4'd1, 4'd3, 12'd0));
    put(15, enc(OPC_MOVI, 4'd2, 4'd0, 12'd1));
    put(16, enc(OPC_ADD,  4'd1, 4'd2, 12'd0));
    put(17, enc(OPC_HLT,  4'd0, 4'd0, 12'd0));
    run_to_halt();
    check("ovf_r1", 32'(dut.r_gp[1]), 32'h800000);
    check("ovf_fl", 32'(dut.r_sr[0]), 32'hA);
    check("ovf_pc", 32'(dut.r_pc), 32'd17);

    // memory, including an address sum that wraps past 0xFFF
    hold_reset();
    put(0, enc(OPC_MOVI, 4'd3, 4'd0, 12'h123));
    put(1, enc(OPC_ST,   4'd3, 4'd0, 12'hFFF));
    put(2, enc(OPC_LD,   4'd4, 4'd0, 12'hFFF));
    put(3, enc(OPC_ST,   4'd3, 4'd3, 12'hEDD));
    put(4, enc(OPC_LD,   4'd5, 4'd0, 12'h000));
    put(5, enc(OPC_HLT,  4'd0, 4'd0, 12'd0));
    run_to_halt();
    check("mem_dmem_fff", 32'(dut.r_dmem[12'hFFF]), 32'h000123);
    check("mem_r4",       32'(dut.r_gp[4]), 32'h000123);
    check("mem_dmem_000", 32'(dut.r_dmem[0]), 32'h000123);
    check("mem_r5",       32'(dut.r_gp[5]), 32'h000123);
    check("mem_ia_count", 32'(ia_cyc.size()), 32'd6);
    if (ia_cyc.size() >= 4) begin
      check("movi_cycles", 32'(ia_cyc[1] - ia_cyc[0]), 32'd5);
      check("st_cycles",   32'(ia_cyc[2] - ia_cyc[1]), 32'd6);
      check("ld_cycles",   32'(ia_cyc[3] - ia_cyc[2]), 32'd7);
    end

    // branches, JAL/RET and reading LR back
    hold_reset();
    put(12'h000, enc(OPC_MOVI,  4'd1,  4'd0, 12'd9));
    put(12'h001, enc(OPC_CMP,   4'd1,  4'd1, 12'd0));
    put(12'h002, enc(OPC_JCC,   CC_EQ, 4'd0, 12'h010));
    put(12'h003, enc(OPC_HLT,   4'd0,  4'd0, 12'd0));
    put(12'h004, enc(OPC_HLT,   4'd0,  4'd0, 12'd0));
    put(12'h005, enc(OPC_JAL,   4'd0,  4'd0, 12'h020));
    put(12'h006, enc(OPC_MOVSR, 4'd6,  4'd1, 12'd0));
    put(12'h007, enc(OPC_HLT,   4'd0,  4'd0, 12'd0));
    put(12'h010, enc(OPC_JCC,   CC_NE, 4'd0, 12'h030));
    put(12'h011, enc(OPC_JCC,   4'h9,  4'd0, 12'h030));
    put(12'h012, enc(OPC_JCC,   CC_AL, 4'd0, 12'h005));
    put(12'h020, enc(OPC_RET,   4'd0,  4'd0, 12'd0));
    put(12'h030, enc(OPC_HLT,   4'd0,  4'd0, 12'd0));
    run_to_halt();
    check("br_trace_len", 32'(trace.size()), 32'd10);
    for (int i = 0; i < 10; i++)
      check($sformatf("br_pc%0d", i), 32'((i < trace.size()) ? trace[i] : 12'hABC), 32'(exp_br[i]));
    check("br_r6", 32'(dut.r_gp[6]), 32'h6);
    check("br_lr", 32'(dut.r_sr[1]), 32'h6);
    check("br_r1", 32'(dut.r_gp[1]), 32'h9);
    check("br_fl", 32'(dut.r_sr[0]), 32'h5);

    // pc wrap 0xFFF -> 0 and CS not-taken / taken
    hold_reset();
    put(12'h000, enc(OPC_JCC, CC_CS, 4'd0, 12'h003));
    put(12'h001, enc(OPC_CMP, 4'd0,  4'd0, 12'd0));
    put(12'h002, enc(OPC_JCC, CC_AL, 4'd0, 12'hFFF));
    put(12'h003, enc(OPC_HLT, 4'd0,  4'd0, 12'd0));
    put(12'hFFF, enc(OPC_NOP, 4'd0,  4'd0, 12'd0));
    run_to_halt();
    check("wrap_trace_len", 32'(trace.size()), 32'd6);
    for (int i = 0; i < 6; i++)
      check($sformatf("wrap_pc%0d", i), 32'((i < trace.size()) ? trace[i] : 12'hABC), 32'(exp_wrap[i]));

    // async reset during EX of the ADD at pc 2
    hold_reset();
    load_arith();
    iw_rst = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (dut.r_pc == 12'd2 && dut.r_phase == PH_EX) found = 1'b1;
      else @(negedge iw_clk);
    end
    check("ex_reached", 32'(dut.r_phase), 32'(PH_EX));
    check("ex_r1_before", 32'(dut.r_gp[1]), 32'h5);
    iw_rst = 1'b0;
    #1;
    check("arst_pc",    32'(dut.r_pc), 32'h0);
    check("arst_phase", 32'(dut.r_phase), 32'(PH_IA));
    check("arst_r1",    32'(dut.r_gp[1]), 32'h0);
    @(posedge iw_clk);
    @(negedge iw_clk);
    check("arst_r1_held",  32'(dut.r_gp[1]), 32'h0);
    check("arst_ssp",      32'(dut.r_sr[3]), 32'h000FFF);
    check("arst_phase_held", 32'(dut.r_phase), 32'(PH_IA));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
